// File: rtl/pulse_frame_pkg.sv
// Shared types and constants for the pulse frame checker.
// The state encoding is visible on the checker's state port, so
// the values below are part of the external interface.
package pulse_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    HIGH  = 2'b10,
    GUARD = 2'b11
  } state_t;

  localparam int PULSE_LEN_DEF = 3;
  localparam int GUARD_LEN_DEF = 2;

  // Width needed for a counter that must hold the larger of the two lengths
  function automatic int cntWidth(input int pulseLen, input int guardLen);
    int maxLen;
    maxLen = (pulseLen > guardLen) ? pulseLen : guardLen;
    return $clog2(maxLen + 1);
  endfunction

endpackage

// File: rtl/pulse_frame_chk_sat_cnt8.sv
// sat_cnt8: 8-bit event counter that sticks at 255 instead of wrapping.
// Cleared only by the asynchronous active-low reset.
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] r_cnt;

  // Count one per inc pulse, holding at all-ones once reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pulse_frame_chk.sv
// pulse_frame_chk: receive-side checker for fixed-width pulse frames.
// A frame is a rising edge, exactly PULSE_LEN high samples, then at least
// GUARD_LEN low samples. One-cycle evt per good frame, err per bad one.
// Optional statistics counters are built when PULSE_FRAME_STATS_EN is
// defined; otherwise ev_cnt/err_cnt read as constant zero.
module pulse_frame_chk
  import pulse_frame_pkg::*;
#(
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int GUARD_LEN = GUARD_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_in,
  output logic       evt,
  output logic       err,
  output logic [1:0] state,
  output logic [7:0] ev_cnt,
  output logic [7:0] err_cnt
);

  localparam int CW = cntWidth(PULSE_LEN, GUARD_LEN);
  localparam logic [CW-1:0] PL  = CW'(PULSE_LEN);
  localparam logic [CW-1:0] GL  = CW'(GUARD_LEN);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_gcnt;
  logic          r_evt;
  logic          r_err;
  logic [CW-1:0] w_gNext;

  assign w_gNext = r_gcnt + ONE;

  // Frame FSM: tracks high/guard phase lengths and emits registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_gcnt  <= '0;
      r_evt   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!p_in) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (p_in) begin
            r_state <= HIGH;
            r_hcnt  <= ONE;
          end
        end
        HIGH: begin
          if (p_in) begin
            if (r_hcnt == PL) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_hcnt <= r_hcnt + ONE;
            end
          end else if (r_hcnt != PL) begin
            r_err   <= 1'b1;
            r_state <= ARMED;
          end else if (GUARD_LEN == 1) begin
            r_evt   <= 1'b1;
            r_state <= ARMED;
          end else begin
            r_state <= GUARD;
            r_gcnt  <= ONE;
          end
        end
        GUARD: begin
          if (p_in) begin
            r_err   <= 1'b1;
            r_state <= HIGH;
            r_hcnt  <= ONE;
          end else if (w_gNext == GL) begin
            r_evt   <= 1'b1;
            r_state <= ARMED;
          end else begin
            r_gcnt <= w_gNext;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign evt   = r_evt;
  assign err   = r_err;
  assign state = r_state;

`ifdef PULSE_FRAME_STATS_EN
  sat_cnt8 u_evCnt (
    .clk (clk),
    .rst (rst),
    .inc (r_evt),
    .cnt (ev_cnt)
  );

  sat_cnt8 u_errCnt (
    .clk (clk),
    .rst (rst),
    .inc (r_err),
    .cnt (err_cnt)
  );
`else
  assign ev_cnt  = 8'd0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pulse_frame_chk.sv
// Directed testbench for pulse_frame_chk with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so each applyStimulus call observes the result of the edge that sampled it.
module tb_pulse_frame_chk;
  import pulse_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       p_in;
  logic       evt;
  logic       err;
  logic [1:0] state;
  logic [7:0] ev_cnt;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

`ifdef PULSE_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pulse_frame_chk dut (
    .clk     (clk),
    .rst     (rst),
    .p_in    (p_in),
    .evt     (evt),
    .err     (err),
    .state   (state),
    .ev_cnt  (ev_cnt),
    .err_cnt (err_cnt)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Safety net so the run cannot hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  // Present one sample to the line and wait for the edge that takes it
  task automatic applyStimulus(input logic v);
    p_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    p_in = 1'b0;
    rst  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    p_in = 1'b1;
    rst  = 1'b0;
    #1;
    checks++;
    if (state !== 2'(IDLE)) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", state, 2'(IDLE)); end
    checks++;
    if ({evt, err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes got=%b exp=00", {evt, err}); end
    checks++;
    if (ev_cnt !== 8'd0 || err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", ev_cnt, err_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1);
      checks++;
      if (state !== 2'(IDLE) || evt !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_high_ignored cycle=%0d got state=%0d evt=%b err=%b exp state=0 evt=0 err=0", i, state, evt, err);
      end
    end
    applyStimulus(1'b0);
    checks++;
    if (state !== 2'(ARMED) || evt !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_arm got state=%0d evt=%b err=%b exp state=1 evt=0 err=0", state, evt, err);
    end
  endtask

  task automatic test_valid_frame();
    doReset();
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checks++;
    if (state !== 2'(HIGH) || evt !== 1'b0) begin errors++; $display("[TB] FAIL valid_high got state=%0d evt=%b exp state=2 evt=0", state, evt); end
    applyStimulus(1'b0);
    checks++;
    if (state !== 2'(GUARD) || evt !== 1'b0) begin errors++; $display("[TB] FAIL valid_guard got state=%0d evt=%b exp state=3 evt=0", state, evt); end
    applyStimulus(1'b0);
    checks++;
    if (evt !== 1'b1 || err !== 1'b0 || state !== 2'(ARMED)) begin
      errors++;
      $display("[TB] FAIL valid_evt got evt=%b err=%b state=%0d exp evt=1 err=0 state=1", evt, err, state);
    end
    applyStimulus(1'b0);
    checks++;
    if (evt !== 1'b0) begin errors++; $display("[TB] FAIL valid_evt_one_cycle got=%b exp=0", evt); end
    checks++;
    if (ev_cnt !== (STATS ? 8'd1 : 8'd0) || err_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL valid_counts got=%0d/%0d exp=%0d/0", ev_cnt, err_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_short_long();
    doReset();
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checks++;
    if (err !== 1'b1 || evt !== 1'b0 || state !== 2'(ARMED)) begin
      errors++;
      $display("[TB] FAIL short_err got err=%b evt=%b state=%0d exp err=1 evt=0 state=1", err, evt, state);
    end
    applyStimulus(1'b0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL short_err_one_cycle got=%b exp=0", err); end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checks++;
    if (err !== 1'b0 || state !== 2'(HIGH)) begin errors++; $display("[TB] FAIL long_third got err=%b state=%0d exp err=0 state=2", err, state); end
    applyStimulus(1'b1);
    checks++;
    if (err !== 1'b1 || evt !== 1'b0 || state !== 2'(IDLE)) begin
      errors++;
      $display("[TB] FAIL long_err got err=%b evt=%b state=%0d exp err=1 evt=0 state=0", err, evt, state);
    end
    applyStimulus(1'b1);
    checks++;
    if (err !== 1'b0 || state !== 2'(IDLE)) begin errors++; $display("[TB] FAIL long_stay_idle got err=%b state=%0d exp err=0 state=0", err, state); end
    applyStimulus(1'b0);
    checks++;
    if (state !== 2'(ARMED) || err_cnt !== (STATS ? 8'd2 : 8'd0)) begin
      errors++;
      $display("[TB] FAIL long_rearm got state=%0d err_cnt=%0d exp state=1 err_cnt=%0d", state, err_cnt, STATS ? 2 : 0);
    end
  endtask

  task automatic test_guard_violation();
    doReset();
    applyStimulus(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checks++;
    if (err !== 1'b1 || evt !== 1'b0 || state !== 2'(HIGH)) begin
      errors++;
      $display("[TB] FAIL guard_err got err=%b evt=%b state=%0d exp err=1 evt=0 state=2", err, evt, state);
    end
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checks++;
    if (err !== 1'b0 || state !== 2'(HIGH)) begin errors++; $display("[TB] FAIL guard_restart got err=%b state=%0d exp err=0 state=2", err, state); end
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checks++;
    if (evt !== 1'b1 || err !== 1'b0 || state !== 2'(ARMED)) begin
      errors++;
      $display("[TB] FAIL guard_recover_evt got evt=%b err=%b state=%0d exp evt=1 err=0 state=1", evt, err, state);
    end
  endtask

  task automatic test_back_to_back();
    int evtSeen;
    int errSeen;
    int misplaced;
    logic [4:0] frame;
    evtSeen   = 0;
    errSeen   = 0;
    misplaced = 0;
    frame     = 5'b11100;
    doReset();
    applyStimulus(1'b0);
    for (int f = 0; f < 300; f++) begin
      for (int k = 4; k >= 0; k--) begin
        applyStimulus(frame[k]);
        if (evt === 1'b1) evtSeen++;
        if (err === 1'b1) errSeen++;
        if (evt !== (k == 0)) misplaced++;
      end
    end
    applyStimulus(1'b0);
    checks++;
    if (evtSeen != 300) begin errors++; $display("[TB] FAIL b2b_evt_count got=%0d exp=300", evtSeen); end
    checks++;
    if (errSeen != 0) begin errors++; $display("[TB] FAIL b2b_err_count got=%0d exp=0", errSeen); end
    checks++;
    if (misplaced != 0) begin errors++; $display("[TB] FAIL b2b_evt_timing got=%0d misplaced exp=0", misplaced); end
    checks++;
    if (ev_cnt !== (STATS ? 8'd255 : 8'd0) || err_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL b2b_saturation got=%0d/%0d exp=%0d/0", ev_cnt, err_cnt, STATS ? 255 : 0);
    end
  endtask

  task automatic test_midframe_reset();
    doReset();
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    p_in = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 2'(IDLE) || evt !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async got state=%0d evt=%b err=%b exp state=0 evt=0 err=0", state, evt, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1);
    checks++;
    if (state !== 2'(IDLE) || err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_high_ignored got state=%0d err=%b exp state=0 err=0", state, err); end
    applyStimulus(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checks++;
    if (evt !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_frame got evt=%b err=%b exp evt=1 err=0", evt, err); end
    rst = 1'b0;
    #1;
    checks++;
    if (evt !== 1'b0 || state !== 2'(IDLE) || ev_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_clears_evt got evt=%b state=%0d ev_cnt=%0d exp evt=0 state=0 ev_cnt=0", evt, state, ev_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Run every scenario in order, then report
  initial begin
    rst  = 1'b1;
    p_in = 1'b0;
    #2;
    test_reset();
    test_valid_frame();
    test_short_long();
    test_guard_violation();
    test_back_to_back();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_frame_chk.md
# pulse_frame_chk

Receive-side checker for the fixed-width pulse frames produced by our 0→1 edge-triggered pulse generator. A frame is a low-to-high edge, exactly PULSE_LEN high cycles, then at least GUARD_LEN low cycles. The block sits on the consuming side of that single-wire link and emits a one-cycle `evt` strobe per well-formed frame and a one-cycle `err` strobe per malformed one. `p_in` is synchronous to `clk`, so there is no synchronizer.

## Interface
- PULSE_LEN, 3, required consecutive high cycles per frame (≥1)
- GUARD_LEN, 2, required consecutive low cycles after the high phase (≥1)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- p_in  input  1  serial pulse line, sampled every rising edge
- evt  output  1  one-cycle strobe, valid frame completed
- err  output  1  one-cycle strobe, frame violation
- state  output  2  current FSM state (encoding in package)
- ev_cnt  output  8  saturating valid-frame count (see Configuration)
- err_cnt  output  8  saturating error count (see Configuration)

## Operation
- Reset values: state=IDLE, evt=0, err=0, ev_cnt=0, err_cnt=0, internal counters 0.
- Internal counters: hcnt and gcnt, each $clog2(max(PULSE_LEN,GUARD_LEN)+1) bits wide.
- **IDLE**: arming state after reset or after an over-long pulse. Moves to ARMED when p_in=0; otherwise stays.
- **ARMED**: line known low.
  - p_in=1 → HIGH, hcnt=1.
  - Otherwise stays.
- **HIGH**:
  - p_in=1, hcnt<PULSE_LEN → hcnt+1.
  - p_in=1, hcnt==PULSE_LEN → err=1, go to IDLE (too long).
  - p_in=0, hcnt<PULSE_LEN → err=1, go to ARMED (too short).
  - p_in=0, hcnt==PULSE_LEN, GUARD_LEN==1 → evt=1, go to ARMED.
  - p_in=0, hcnt==PULSE_LEN, GUARD_LEN>1 → GUARD, gcnt=1.
- **GUARD**:
  - p_in=0, gcnt+1==GUARD_LEN → evt=1, go to ARMED.
  - p_in=0, otherwise → gcnt+1.
  - p_in=1 → err=1, go to HIGH with hcnt=1. The violating high counts as the start of a new frame.
- evt and err are registered, high for exactly one cycle, and never high together.
- Back-to-back frames are legal: after evt the block is in ARMED and accepts a high on the very next sample.

## Timing
- Latency: evt rises on the edge that samples the GUARD_LEN-th low after the pulse.
- Default timeline: high samples at edges E0..E2, lows at E3 and E4. evt is high in the cycle following E4.
- err rises on the edge that samples the offending value.
- Asynchronous reset mid-frame forces IDLE immediately and clears evt/err in the same instant. After release, one low sample is needed before any frame is accepted; a line held high at reset release is ignored until it drops.

## Configuration
- PULSE_FRAME_STATS_EN defined:
  - ev_cnt increments on each evt; err_cnt increments on each err.
  - Both saturate at 255, with no wrap.
  - Both are cleared only by rst.
- PULSE_FRAME_STATS_EN undefined: ev_cnt and err_cnt ports remain and are tied to 0; no counter flops are synthesized.

## Structure
- Package pulse_frame_pkg:
  - State type: IDLE=2'b00, ARMED=2'b01, HIGH=2'b10, GUARD=2'b11.
  - Default constants PULSE_LEN_DEF=3 and GUARD_LEN_DEF=2.
- Sub-module sat_cnt8: 8-bit saturating incrementer with inc input, async active-low reset. Instantiated twice under PULSE_FRAME_STATS_EN.

## Test plan
- **Reset with p_in=1 for 5 cycles, then 0** → state stays IDLE during the highs, then ARMED; no evt/err.
- **Default params, line low, then 3 high / 2 low** → exactly one evt, one cycle after the 2nd low sample; state returns to ARMED; ev_cnt=1 with the macro.
- **2 high then low** → err on the low sample, state ARMED; **4 high** → err on the 4th high sample, state IDLE.
- **3 high, 1 low, then high** → err on the re-rise, state HIGH with hcnt=1. Then 2 more highs and 2 lows → evt.
- **300 valid frames back-to-back** → 300 evt strobes; ev_cnt saturates at 255 with the macro and reads 0 without it.
- **rst asserted during the 2nd high cycle** → immediate IDLE, evt=err=0. Then 1 low and a valid frame → one evt.
